soc_event_queue: RTL and testbench
==================================

// Module: soc_event_queue
// PURPOSE
//  Collects single-cycle event pulses from up to N_SRC peripheral/SoC sources, arbitrates them round-robin
//  and queues the source index in a FIFO. Drains as an 8-bit valid/ready event stream directly into the
//  uDMA subsystem's event input (event_valid_i / event_data_i / event_ready_o) in the pulp_io domain.
// PARAMETERS
//  N_SRC       32  number of event sources, 1..256
//  FIFO_DEPTH  8   queue entries, power of two, >=2
//  EVT_W       8   output event width; source index is zero-extended to EVT_W
// PORTS
//  sys_clk_i       in   1          single clock, all logic rising-edge
//  sys_resetn_i    in   1          asynchronous active-low reset
//  evt_i           in   N_SRC      per-source event pulse, 1 cycle = 1 event
//  evt_valid_o     out  1          queue head valid
//  evt_data_o      out  EVT_W      source index of queue head
//  evt_ready_i     in   1          consumer accepts head when valid&&ready
//  fifo_full_o     out  1          queue full, registered
//  drop_o          out  1          1-cycle pulse: >=1 event lost this cycle
// BEHAVIOUR
//  Reset: pending=0, FIFO empty, rr pointer=0; evt_valid_o=0, evt_data_o=0, fifo_full_o=0, drop_o=0.
//  Pending: pend[i] set on evt_i[i]; cleared when source i is pushed. evt_i[i] in the same cycle as
//    the push of i keeps pend[i]=1 (new event, not lost). evt_i[i] while pend[i]=1 and i not pushed
//    that cycle -> event lost, drop_o=1 next cycle.
//  Arbitration: if pend!=0 and !full (registered, pre-pop value), push exactly one index per cycle,
//    chosen round-robin starting at rr pointer; pointer then = granted index+1, mod N_SRC.
//    Push is blocked when full even if a pop occurs in the same cycle (deterministic; costs 1 cycle).
//  Latency: evt_i at edge t -> pend at t+1 -> pushed at t+2 -> evt_valid_o=1 after t+2 (2 cycles, idle queue).
//  Output: evt_valid_o = !empty; evt_data_o = head, zero-extended; stable while valid&&!ready.
//    Pop on valid&&ready; ready while empty ignored. Push+pop same cycle: count unchanged.
//  Pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSB differ & rest equal; empty = equal.
//  No flush input; only reset clears state. Reset mid-transfer discards queue and pending events.
// CONFIGURATION
//  SOC_EVENT_QUEUE_DROP_CNT_EN defined: adds output drop_cnt_o[15:0] counting lost events (multiple
//    in one cycle add their popcount), saturating at 16'hFFFF, reset 0, cleared by input drop_cnt_clr_i
//    (clear wins over same-cycle increment). Undefined: neither port exists; drop_o unchanged.
// STRUCTURE
//  Shared package soc_event_pkg: EVT_W, default N_SRC/FIFO_DEPTH, evt_idx_t typedef.
//  One sub-module: soc_event_rr_arb (N_SRC req, one-hot grant + index, rr pointer update on grant).
//  FIFO storage inline in this module (flops).
// TESTING
//  Single pulse evt_i[5], ready=1 -> evt_valid_o=1 two cycles later, evt_data_o=8'h05, one beat only.
//  evt_i=32'h0000_0111 one cycle, rr ptr 0, ready=1 -> outputs 0,4,8 on consecutive cycles.
//  ready=0, pulse sources 0..8 on separate cycles -> 8 queued, fifo_full_o=1, pend[8] held; ready=1
//    -> drains 0..8 in order, no drop_o.
//  evt_i[3] two cycles back-to-back while full -> second pulse: drop_o=1 one cycle; with
//    SOC_EVENT_QUEUE_DROP_CNT_EN drop_cnt_o=1, drop_cnt_clr_i -> 0.
//  All 32 sources pulsed every cycle, ready toggling -> every index appears, max gap N_SRC grants per source.
//  Assert sys_resetn_i with 4 entries queued, mid-handshake -> evt_valid_o=0 immediately, nothing replayed.

Source files
------------

// File: rtl/soc_event_pkg.sv
// Shared types and defaults for the SoC event queue and its round-robin arbiter.
package soc_event_pkg;
  localparam int EVT_W          = 8;
  localparam int N_SRC_DEF      = 32;
  localparam int FIFO_DEPTH_DEF = 8;

  // Up to 256 sources, so an EVT_W-wide index always holds the source number.
  typedef logic [EVT_W-1:0] evt_idx_t;
endpackage

// File: rtl/soc_event_rr_arb.sv
// Round-robin arbiter: grants at most one request per cycle, searching upward
// from the pointer; the pointer moves to granted index + 1 (mod N_SRC).
module soc_event_rr_arb
  import soc_event_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_SRC-1:0] i_req,
  input  logic             i_en,
  output logic             o_gnt_vld,
  output logic [N_SRC-1:0] o_gnt,
  output evt_idx_t         o_gnt_idx
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [IW:0] NS = (IW+1)'(N_SRC);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_nxt;
  logic [IW-1:0] w_gidx;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt     = '0;
    w_gidx    = '0;
    w_sum     = '0;
    w_j       = '0;
    if (i_en) begin
      for (int k = 0; k < N_SRC; k++) begin
        w_sum = {1'b0, r_ptr} + (IW+1)'(k);
        if (w_sum >= NS) w_sum = w_sum - NS;
        w_j = w_sum[IW-1:0];
        if (!o_gnt_vld && i_req[w_j]) begin
          o_gnt_vld  = 1'b1;
          o_gnt[w_j] = 1'b1;
          w_gidx     = w_j;
        end
      end
    end
  end

  assign o_gnt_idx = evt_idx_t'(w_gidx);

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (o_gnt_vld) w_ptr_nxt = ({1'b0, w_gidx} == NS - 1'b1) ? '0 : w_gidx + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ptr <= '0;
    else          r_ptr <= w_ptr_nxt;
  end
endmodule

// File: rtl/soc_event_queue.sv
// Event pulse collector: per-source pending bits, round-robin push into a FIFO,
// valid/ready drain. Optional lost-event counter under SOC_EVENT_QUEUE_DROP_CNT_EN.
module soc_event_queue
  import soc_event_pkg::*;
#(
  parameter int N_SRC      = N_SRC_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             sys_clk_i,
  input  logic             sys_resetn_i,
  input  logic [N_SRC-1:0] evt_i,
  output logic             evt_valid_o,
  output logic [EVT_W-1:0] evt_data_o,
  input  logic             evt_ready_i,
  output logic             fifo_full_o,
  output logic             drop_o
`ifdef SOC_EVENT_QUEUE_DROP_CNT_EN
  ,
  input  logic             drop_cnt_clr_i,
  output logic [15:0]      drop_cnt_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] w_gnt;
  logic [N_SRC-1:0] w_lost;
  logic             w_push;
  evt_idx_t         w_gnt_idx;
  logic             w_pop;
  logic             w_empty;
  logic [AW:0]      r_wptr, r_rptr;
  logic [AW:0]      w_wptr_nxt, w_rptr_nxt;
  logic             r_full, r_drop;
  evt_idx_t         r_mem [FIFO_DEPTH];

  // Full gates the push on the registered value, so a same-cycle pop cannot free a slot.
  soc_event_rr_arb #(.N_SRC(N_SRC)) u_arb (
    .i_clk     (sys_clk_i),
    .i_rst_n   (sys_resetn_i),
    .i_req     (r_pend),
    .i_en      (!r_full),
    .o_gnt_vld (w_push),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_empty    = (r_wptr == r_rptr);
  assign w_pop      = evt_ready_i && !w_empty;
  assign w_lost     = evt_i & r_pend & ~w_gnt;
  assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};

  always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
    if (!sys_resetn_i) begin
      r_pend <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_gnt) | evt_i;
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      r_full <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
      r_drop <= |w_lost;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_gnt_idx;
  end

  assign evt_valid_o = !w_empty;
  assign evt_data_o  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign fifo_full_o = r_full;
  assign drop_o      = r_drop;

`ifdef SOC_EVENT_QUEUE_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic [16:0] w_cnt_sum;

  assign w_cnt_sum = {1'b0, r_drop_cnt} + 17'($countones(w_lost));

  always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
    if (!sys_resetn_i)       r_drop_cnt <= '0;
    else if (drop_cnt_clr_i) r_drop_cnt <= '0;
    else if (w_cnt_sum[16])  r_drop_cnt <= 16'hFFFF;
    else                     r_drop_cnt <= w_cnt_sum[15:0];
  end

  assign drop_cnt_o = r_drop_cnt;
`endif
endmodule

// File: tb/tb_soc_event_queue.sv
// Directed bench for soc_event_queue: vector table plus hand sequences for
// round-robin fairness, reset mid-handshake and the optional drop counter.
module tb_soc_event_queue;
  logic        clk;
  logic        rstn;
  logic [31:0] evt;
  logic        rdy;
  logic        valid;
  logic [7:0]  data;
  logic        full;
  logic        drop;
`ifdef SOC_EVENT_QUEUE_DROP_CNT_EN
  logic        clr;
  logic [15:0] dcnt;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  soc_event_queue #(.N_SRC(32), .FIFO_DEPTH(8)) dut (
    .sys_clk_i    (clk),
    .sys_resetn_i (rstn),
    .evt_i        (evt),
    .evt_valid_o  (valid),
    .evt_data_o   (data),
    .evt_ready_i  (rdy),
    .fifo_full_o  (full),
    .drop_o       (drop)
`ifdef SOC_EVENT_QUEUE_DROP_CNT_EN
    ,
    .drop_cnt_clr_i (clr),
    .drop_cnt_o     (dcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rstn;
    logic [31:0] evt;
    logic        rdy;
    logic        chk;
    logic        v;
    logic [7:0]  d;
    logic        f;
    logic        dr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic rst_row();
    tbl.push_back('{rstn: 1'b0, evt: '0, rdy: 1'b0, chk: 1'b0, v: 1'b0, d: '0, f: 1'b0, dr: 1'b0});
  endtask

  // Expected outputs describe the state seen during this row, before its inputs are clocked in.
  task automatic row(input logic [31:0] e, input logic r, input logic v,
                     input logic [7:0] d, input logic f, input logic dr);
    tbl.push_back('{rstn: 1'b1, evt: e, rdy: r, chk: 1'b1, v: v, d: d, f: f, dr: dr});
  endtask

  task automatic hard_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [7:0] drain [9];
    logic [31:0] seen;
    int last [32];
    int npop, maxgap, idx;
    logic anydrop, badidx;

    rstn = 1'b0; evt = '0; rdy = 1'b0;
`ifdef SOC_EVENT_QUEUE_DROP_CNT_EN
    clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_valid", {31'b0, valid}, 32'd0);
    chk("reset_data",  {24'b0, data},  32'd0);
    chk("reset_full",  {31'b0, full},  32'd0);
    chk("reset_drop",  {31'b0, drop},  32'd0);
`ifdef SOC_EVENT_QUEUE_DROP_CNT_EN
    chk("reset_dcnt",  {16'b0, dcnt},  32'd0);
`endif

    // single pulse on source 5: visible two cycles later, one beat
    rst_row();
    row(32'h1 << 5, 1, 0, 0, 0, 0);
    row(0, 1, 0, 0, 0, 0);
    row(0, 1, 1, 8'h05, 0, 0);
    row(0, 1, 0, 0, 0, 0);

    // three simultaneous sources drain in rr order from pointer 0
    rst_row();
    row(32'h111, 1, 0, 0, 0, 0);
    row(0, 1, 0, 0, 0, 0);
    row(0, 1, 1, 8'h00, 0, 0);
    row(0, 1, 1, 8'h04, 0, 0);
    row(0, 1, 1, 8'h08, 0, 0);
    row(0, 1, 0, 0, 0, 0);

    // fill to full with sources 0..8, pend[8] held, double pulse on 3 loses one
    rst_row();
    for (int k = 0; k < 9; k++) row(32'h1 << k, 0, (k >= 2), 8'h00, 0, 0);
    row(0, 0, 1, 8'h00, 1, 0);
    row(32'h1 << 3, 0, 1, 8'h00, 1, 0);
    row(32'h1 << 3, 0, 1, 8'h00, 1, 0);
    row(0, 0, 1, 8'h00, 1, 1);
    row(0, 1, 1, 8'h00, 1, 0);
    drain = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd3};
    foreach (drain[i]) row(0, 1, 1, drain[i], 0, 0);
    row(0, 1, 0, 0, 0, 0);

    // re-pulse in the cycle the source is pushed: a second event, not a loss
    rst_row();
    row(32'h1 << 2, 1, 0, 0, 0, 0);
    row(32'h1 << 2, 1, 0, 0, 0, 0);
    row(0, 1, 1, 8'h02, 0, 0);
    row(0, 1, 1, 8'h02, 0, 0);
    row(0, 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].chk) begin
        chk($sformatf("row%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].v});
        chk($sformatf("row%0d_full",  i), {31'b0, full},  {31'b0, tbl[i].f});
        chk($sformatf("row%0d_drop",  i), {31'b0, drop},  {31'b0, tbl[i].dr});
        if (tbl[i].v) chk($sformatf("row%0d_data", i), {24'b0, data}, {24'b0, tbl[i].d});
      end
      rstn = tbl[i].rstn;
      evt  = tbl[i].evt;
      rdy  = tbl[i].rdy;
      @(negedge clk);
    end

    // all sources pulsed every cycle with ready toggling: strict rotation
    hard_reset();
    seen = '0; npop = 0; maxgap = 0; anydrop = 1'b0; badidx = 1'b0;
    foreach (last[i]) last[i] = 0;
    evt = '1;
    for (int c = 0; c < 300; c++) begin
      rdy = c[0];
      if (drop) anydrop = 1'b1;
      if (valid && rdy) begin
        idx = int'(data);
        if (idx >= 32) badidx = 1'b1;
        else begin
          if (seen[idx] && (npop - last[idx] > maxgap)) maxgap = npop - last[idx];
          seen[idx] = 1'b1;
          last[idx] = npop;
        end
        npop++;
      end
      @(negedge clk);
    end
    evt = '0; rdy = 1'b0;
    chk("stress_all_seen", seen, 32'hFFFF_FFFF);
    chk("stress_max_gap",  maxgap, 32);
    chk("stress_idx_range", {31'b0, badidx}, 32'd0);
    chk("stress_drop_seen", {31'b0, anydrop}, 32'd1);

    // reset with 4 queued, pend[4] set and a handshake in progress
    hard_reset();
    evt = 32'hF;
    @(negedge clk);
    evt = 32'h10;
    @(negedge clk);
    evt = '0;
    repeat (3) @(negedge clk);
    chk("midrst_pre_valid", {31'b0, valid}, 32'd1);
    chk("midrst_pre_data",  {24'b0, data},  32'd0);
    rdy = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, valid}, 32'd0);
    chk("midrst_data",  {24'b0, data},  32'd0);
    chk("midrst_full",  {31'b0, full},  32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_replay%0d", c), {31'b0, valid}, 32'd0);
    end
    rdy = 1'b0;

`ifdef SOC_EVENT_QUEUE_DROP_CNT_EN
    // two losses in one cycle add 2; clear beats a same-cycle loss
    hard_reset();
    evt = 32'h7;
    @(negedge clk);
    @(negedge clk);
    chk("dcnt_pop2_drop", {31'b0, drop}, 32'd1);
    chk("dcnt_pop2",      {16'b0, dcnt}, 32'd2);
    evt = 32'h4; clr = 1'b1;
    @(negedge clk);
    evt = '0; clr = 1'b0;
    chk("dcnt_clr_drop", {31'b0, drop}, 32'd1);
    chk("dcnt_clr",      {16'b0, dcnt}, 32'd0);
    @(negedge clk);
    chk("dcnt_idle_drop", {31'b0, drop}, 32'd0);
    chk("dcnt_idle",      {16'b0, dcnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
